dbg_halt_ctrl: RTL and testbench

- Debug-mode entry/exit sequencer for the core.
- Consumes the hardware-trigger `breakpoint` pulse, EX-stage `ebreak`, and the debug module's halt/resume requests.
- Captures DPC and the DCSR cause, then flushes the pipeline through a req/ack handshake and drives `dbg_mode`.
- On resume, redirects fetch to DPC; optionally single-steps one instruction.

---
 rtl/dbg_halt_ctrl_pkg.sv | 21 ++
 rtl/dbg_halt_ctrl_if.sv | 42 ++++
 rtl/dbg_halt_ctrl_cause_prio.sv | 25 ++
 rtl/dbg_halt_ctrl.sv | 132 +++++++++++++
 tb/tb_dbg_halt_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_halt_ctrl_pkg.sv
// Shared definitions for the debug halt controller: DCSR cause codes and
// the 3-bit binary encoding of the entry/exit sequencer states.
package dbg_halt_ctrl_pkg;

  localparam int DBG_CAUSE_BITS = 3;

  localparam logic [DBG_CAUSE_BITS-1:0] DBG_CAUSE_NONE    = 3'd0;
  localparam logic [DBG_CAUSE_BITS-1:0] DBG_CAUSE_EBREAK  = 3'd1;
  localparam logic [DBG_CAUSE_BITS-1:0] DBG_CAUSE_TRIGGER = 3'd2;
  localparam logic [DBG_CAUSE_BITS-1:0] DBG_CAUSE_HALTREQ = 3'd3;
  localparam logic [DBG_CAUSE_BITS-1:0] DBG_CAUSE_STEP    = 3'd4;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_HALTED = 3'd2,
    ST_RESUME = 3'd3,
    ST_STEP   = 3'd4
  } dbg_state_e;

endpackage

// File: rtl/dbg_halt_ctrl_if.sv
// Signal bundle between the core/debug module and the debug halt controller.
// slave: the controller; master: the core pipeline and debug module side.
interface dbg_halt_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CAUSE_W    = 3
);
  logic                  breakpoint;
  logic                  ebreak_ex;
  logic                  halt_req;
  logic                  resume_req;
  logic                  dcsr_step;
  logic                  ex_valid;
  logic [ADDR_WIDTH-1:0] pc_ex;
  logic                  retire;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  flush_ack;
  logic                  dpc_wr_en;
  logic [ADDR_WIDTH-1:0] dpc_wr_data;
  logic                  flush_req;
  logic                  dbg_mode;
  logic                  halted;
  logic                  resume_ack;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] dpc;
  logic [CAUSE_W-1:0]    dcsr_cause;

  modport slave (
    input  breakpoint, ebreak_ex, halt_req, resume_req, dcsr_step, ex_valid,
           pc_ex, retire, pc_next, flush_ack, dpc_wr_en, dpc_wr_data,
    output flush_req, dbg_mode, halted, resume_ack, redirect_valid,
           redirect_pc, dpc, dcsr_cause
  );

  modport master (
    output breakpoint, ebreak_ex, halt_req, resume_req, dcsr_step, ex_valid,
           pc_ex, retire, pc_next, flush_ack, dpc_wr_en, dpc_wr_data,
    input  flush_req, dbg_mode, halted, resume_ack, redirect_valid,
           redirect_pc, dpc, dcsr_cause
  );

endinterface

// File: rtl/dbg_halt_ctrl_cause_prio.sv
// Debug-entry priority encoder: trigger > ebreak > haltreq > step.
// Events arrive already qualified by the sequencer state and ex_valid.
module dbg_cause_prio
  import dbg_halt_ctrl_pkg::*;
(
  input  logic                      breakpoint,
  input  logic                      ebreak_ex,
  input  logic                      halt_req,
  input  logic                      step_done,
  output logic                      take,
  output logic [DBG_CAUSE_BITS-1:0] cause
);

  // Pick the highest-priority pending entry reason
  always_comb begin
    take  = 1'b1;
    cause = DBG_CAUSE_NONE;
    if (breakpoint)     cause = DBG_CAUSE_TRIGGER;
    else if (ebreak_ex) cause = DBG_CAUSE_EBREAK;
    else if (halt_req)  cause = DBG_CAUSE_HALTREQ;
    else if (step_done) cause = DBG_CAUSE_STEP;
    else                take  = 1'b0;
  end

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug-mode entry/exit sequencer: captures DPC and cause, drains the
// pipeline via flush_req/flush_ack, holds in HALTED, and redirects fetch to
// DPC on resume. Define KRV_DBG_STEP_EN to build the single-step state.
module dbg_halt_ctrl
  import dbg_halt_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CAUSE_W    = 3
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  dbg_halt_ctrl_if.slave  dbg
);

  dbg_state_e              state;
  logic                    flush_req_q;
  logic                    dbg_mode_q;
  logic                    halted_q;
  logic                    resume_ack_q;
  logic                    redirect_valid_q;
  logic [ADDR_WIDTH-1:0]   dpc_q;
  logic [CAUSE_W-1:0]      cause_q;

  logic                    ev_bp;
  logic                    ev_eb;
  logic                    ev_hr;
  logic                    ev_sd;
  logic                    take;
  logic [DBG_CAUSE_BITS-1:0] prio_cause;
  logic                    step_go;

`ifdef KRV_DBG_STEP_EN
  assign step_go = dbg.dcsr_step;
`else
  logic unused_step_inputs;
  assign step_go            = 1'b0;
  assign unused_step_inputs = ^{dbg.dcsr_step, dbg.retire, dbg.pc_next};
`endif

  // Gate raw events by state: RUN takes all but step, STEP takes trigger/ebreak/retire
  always_comb begin
    ev_bp = 1'b0;
    ev_eb = 1'b0;
    ev_hr = 1'b0;
    ev_sd = 1'b0;
    case (state)
      ST_RUN: begin
        ev_bp = dbg.breakpoint & dbg.ex_valid;
        ev_eb = dbg.ebreak_ex  & dbg.ex_valid;
        ev_hr = dbg.halt_req   & dbg.ex_valid;
      end
`ifdef KRV_DBG_STEP_EN
      ST_STEP: begin
        ev_bp = dbg.breakpoint & dbg.ex_valid;
        ev_eb = dbg.ebreak_ex  & dbg.ex_valid;
        ev_sd = dbg.retire;
      end
`endif
      default: ;
    endcase
  end

  dbg_cause_prio u_prio (
    .breakpoint (ev_bp),
    .ebreak_ex  (ev_eb),
    .halt_req   (ev_hr),
    .step_done  (ev_sd),
    .take       (take),
    .cause      (prio_cause)
  );

  // Sequencer FSM with registered handshake/status outputs and DPC/cause capture
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state            <= ST_RUN;
      flush_req_q      <= 1'b0;
      dbg_mode_q       <= 1'b0;
      halted_q         <= 1'b0;
      resume_ack_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      dpc_q            <= '0;
      cause_q          <= '0;
    end else begin
      case (state)
        ST_RUN, ST_STEP: begin
          if (take) begin
            // A completed step records the next PC; everything else records EX
            dpc_q       <= (prio_cause == DBG_CAUSE_STEP) ? dbg.pc_next : dbg.pc_ex;
            cause_q     <= CAUSE_W'(prio_cause);
            flush_req_q <= 1'b1;
            state       <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (dbg.flush_ack) begin
            flush_req_q <= 1'b0;
            dbg_mode_q  <= 1'b1;
            halted_q    <= 1'b1;
            state       <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          // The write lands on the same edge as resume, so RESUME sees the new DPC
          if (dbg.dpc_wr_en) dpc_q <= dbg.dpc_wr_data;
          if (dbg.resume_req) begin
            redirect_valid_q <= 1'b1;
            resume_ack_q     <= 1'b1;
            state            <= ST_RESUME;
          end
        end
        ST_RESUME: begin
          redirect_valid_q <= 1'b0;
          resume_ack_q     <= 1'b0;
          dbg_mode_q       <= 1'b0;
          halted_q         <= 1'b0;
          state            <= step_go ? ST_STEP : ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign dbg.flush_req      = flush_req_q;
  assign dbg.dbg_mode       = dbg_mode_q;
  assign dbg.halted         = halted_q;
  assign dbg.resume_ack     = resume_ack_q;
  assign dbg.redirect_valid = redirect_valid_q;
  assign dbg.redirect_pc    = dpc_q;
  assign dbg.dpc            = dpc_q;
  assign dbg.dcsr_cause     = cause_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Directed bench for dbg_halt_ctrl. Expected output snapshots are queued as
// each step's stimulus is driven and popped/compared one edge later.
// The step tests follow the same KRV_DBG_STEP_EN macro as the design.
module tb_dbg_halt_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dbg_halt_ctrl_if #(.ADDR_WIDTH(32), .CAUSE_W(3)) bus ();

  dbg_halt_ctrl #(.ADDR_WIDTH(32), .CAUSE_W(3)) dut (
    .cpu_clk (clk),
    .cpu_rst (rst),
    .dbg     (bus)
  );

  typedef struct {
    string       tag;
    logic        fr;
    logic        dm;
    logic        hl;
    logic        ra;
    logic        rv;
    logic [31:0] pc;
    logic [2:0]  cause;
  } exp_t;

  exp_t sb[$];

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "flush_req",      32'(bus.flush_req),      32'(e.fr));
      cmp(e.tag, "dbg_mode",       32'(bus.dbg_mode),       32'(e.dm));
      cmp(e.tag, "halted",         32'(bus.halted),         32'(e.hl));
      cmp(e.tag, "resume_ack",     32'(bus.resume_ack),     32'(e.ra));
      cmp(e.tag, "redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
      cmp(e.tag, "redirect_pc",    bus.redirect_pc,         e.pc);
      cmp(e.tag, "dpc",            bus.dpc,                 e.pc);
      cmp(e.tag, "dcsr_cause",     32'(bus.dcsr_cause),     32'(e.cause));
    end
  endtask

  // Queue the expected snapshot, clock one edge, then check the DUT against it
  task automatic step(input string tag, input logic fr, input logic dm, input logic hl,
                      input logic ra, input logic rv, input logic [31:0] pc,
                      input logic [2:0] cs);
    exp_t e;
    e.tag = tag; e.fr = fr; e.dm = dm; e.hl = hl; e.ra = ra; e.rv = rv;
    e.pc = pc; e.cause = cs;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic clr();
    bus.breakpoint = 1'b0;
    bus.ebreak_ex  = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume_req = 1'b0;
    bus.ex_valid   = 1'b0;
    bus.retire     = 1'b0;
    bus.flush_ack  = 1'b0;
    bus.dpc_wr_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    bus.dcsr_step   = 1'b0;
    bus.pc_ex       = '0;
    bus.pc_next     = '0;
    bus.dpc_wr_data = '0;

    // reset state
    step("rst_a", 0, 0, 0, 0, 0, 32'h0, 3'd0);
    step("rst_b", 0, 0, 0, 0, 0, 32'h0, 3'd0);
    rst = 1'b0;

    // trigger entry, ack three cycles after capture
    bus.ex_valid = 1'b1; bus.pc_ex = 32'h100; bus.breakpoint = 1'b1;
    step("t1_capture", 1, 0, 0, 0, 0, 32'h100, 3'd2);
    clr();
    step("t1_flush_a", 1, 0, 0, 0, 0, 32'h100, 3'd2);
    step("t1_flush_b", 1, 0, 0, 0, 0, 32'h100, 3'd2);
    bus.flush_ack = 1'b1;
    step("t1_ack", 0, 1, 1, 0, 0, 32'h100, 3'd2);
    clr();

    // HALTED ignores trigger, ebreak and halt_req
    bus.ex_valid = 1'b1; bus.pc_ex = 32'h999; bus.breakpoint = 1'b1;
    bus.ebreak_ex = 1'b1; bus.halt_req = 1'b1;
    step("halted_ignore", 0, 1, 1, 0, 0, 32'h100, 3'd2);
    clr();

    // DPC write coincident with resume; writes outside HALTED are dropped
    bus.dpc_wr_en = 1'b1; bus.dpc_wr_data = 32'h8000; bus.resume_req = 1'b1;
    step("t4_resume", 0, 1, 1, 1, 1, 32'h8000, 3'd2);
    bus.dpc_wr_data = 32'hdead;
    step("t4_exit", 0, 0, 0, 0, 0, 32'h8000, 3'd2);
    step("t4_run_resume_held", 0, 0, 0, 0, 0, 32'h8000, 3'd2);
    clr();

    // coincident events: trigger wins, ack in the first FLUSH cycle
    bus.ex_valid = 1'b1; bus.pc_ex = 32'h200;
    bus.breakpoint = 1'b1; bus.ebreak_ex = 1'b1; bus.halt_req = 1'b1;
    step("t2_capture", 1, 0, 0, 0, 0, 32'h200, 3'd2);
    clr();
    bus.flush_ack = 1'b1;
    step("t2_ack", 0, 1, 1, 0, 0, 32'h200, 3'd2);
    clr();
    step("t2_single", 0, 1, 1, 0, 0, 32'h200, 3'd2);
    bus.resume_req = 1'b1;
    step("t2_resume", 0, 1, 1, 1, 1, 32'h200, 3'd2);
    clr();
    step("t2_run", 0, 0, 0, 0, 0, 32'h200, 3'd2);

    // halt_req waits for ex_valid
    bus.halt_req = 1'b1; bus.pc_ex = 32'h344;
    for (int i = 0; i < 4; i++) step("t3_wait", 0, 0, 0, 0, 0, 32'h200, 3'd2);
    bus.ex_valid = 1'b1;
    step("t3_capture", 1, 0, 0, 0, 0, 32'h344, 3'd3);
    bus.pc_ex = 32'h355; bus.breakpoint = 1'b1;
    step("t3_flush_ignore", 1, 0, 0, 0, 0, 32'h344, 3'd3);
    bus.ex_valid = 1'b0; bus.breakpoint = 1'b0; bus.flush_ack = 1'b1;
    step("t3_ack", 0, 1, 1, 0, 0, 32'h344, 3'd3);
    bus.flush_ack = 1'b0;
    step("t3_halted_hreq", 0, 1, 1, 0, 0, 32'h344, 3'd3);
    // halt_req still high through resume re-halts at the next valid EX
    bus.resume_req = 1'b1;
    step("t3_resume", 0, 1, 1, 1, 1, 32'h344, 3'd3);
    bus.resume_req = 1'b0; bus.ex_valid = 1'b1; bus.pc_ex = 32'h400;
    step("t3_exit", 0, 0, 0, 0, 0, 32'h344, 3'd3);
    step("t3_rehalt", 1, 0, 0, 0, 0, 32'h400, 3'd3);
    clr();
    bus.flush_ack = 1'b1;
    step("t3_ack2", 0, 1, 1, 0, 0, 32'h400, 3'd3);
    clr();
    bus.resume_req = 1'b1;
    step("t3_resume2", 0, 1, 1, 1, 1, 32'h400, 3'd3);
    clr();
    step("t3_run", 0, 0, 0, 0, 0, 32'h400, 3'd3);

    // ebreak entry, then reset while flushing
    bus.ex_valid = 1'b1; bus.pc_ex = 32'h500; bus.ebreak_ex = 1'b1;
    step("t6_capture", 1, 0, 0, 0, 0, 32'h500, 3'd1);
    clr();
    rst = 1'b1;
    step("t6_reset", 0, 0, 0, 0, 0, 32'h0, 3'd0);
    rst = 1'b0;
    bus.ex_valid = 1'b1; bus.pc_ex = 32'h600; bus.breakpoint = 1'b1;
    step("t6_run_again", 1, 0, 0, 0, 0, 32'h600, 3'd2);
    clr();
    bus.flush_ack = 1'b1;
    step("t6_ack", 0, 1, 1, 0, 0, 32'h600, 3'd2);
    clr();

    // single step
    bus.dcsr_step = 1'b1; bus.resume_req = 1'b1;
    step("t5_resume", 0, 1, 1, 1, 1, 32'h600, 3'd2);
    bus.resume_req = 1'b0;
`ifdef KRV_DBG_STEP_EN
    step("t5_in_step", 0, 0, 0, 0, 0, 32'h600, 3'd2);
    bus.halt_req = 1'b1; bus.ex_valid = 1'b1; bus.pc_ex = 32'h8000;
    step("t5_step_hreq", 0, 0, 0, 0, 0, 32'h600, 3'd2);
    clr();
    bus.retire = 1'b1; bus.pc_next = 32'h8004;
    step("t5_step_cap", 1, 0, 0, 0, 0, 32'h8004, 3'd4);
    clr();
    bus.flush_ack = 1'b1;
    step("t5_ack", 0, 1, 1, 0, 0, 32'h8004, 3'd4);
    clr();
    bus.resume_req = 1'b1;
    step("t5_resume2", 0, 1, 1, 1, 1, 32'h8004, 3'd4);
    clr();
    step("t5_in_step2", 0, 0, 0, 0, 0, 32'h8004, 3'd4);
    bus.ex_valid = 1'b1; bus.pc_ex = 32'h8004; bus.breakpoint = 1'b1;
    bus.retire = 1'b1; bus.pc_next = 32'h8008;
    step("t5_bp_wins", 1, 0, 0, 0, 0, 32'h8004, 3'd2);
    clr();
    bus.flush_ack = 1'b1;
    step("t5_ack2", 0, 1, 1, 0, 0, 32'h8004, 3'd2);
    clr();
    bus.dcsr_step = 1'b0; bus.resume_req = 1'b1;
    step("t5_resume3", 0, 1, 1, 1, 1, 32'h8004, 3'd2);
    clr();
    step("t5_run", 0, 0, 0, 0, 0, 32'h8004, 3'd2);
`else
    step("t5_no_step", 0, 0, 0, 0, 0, 32'h600, 3'd2);
    bus.retire = 1'b1; bus.pc_next = 32'h8004;
    step("t5_retire_ignored", 0, 0, 0, 0, 0, 32'h600, 3'd2);
    clr();
    bus.dcsr_step = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
